// File: rtl/aclk_display_ctrl_if.sv
// Keypad/button inputs and display-select/load-strobe outputs of the alarm clock display controller.
// Latency: none; a plain bundle of wires with no storage.
// Backpressure: none; every signal is a level or a one-cycle strobe with no handshake.
//
// Port summary:
//   one_second                : 1 Hz single-cycle enable pulse
//   key[3:0]                  : keypad code, NOKEY when idle
//   alarm_button, time_button : button levels
//   show_a, show_new_time     : display source selects
//   load_new_a, load_new_c    : commit strobes
//   shift                     : key-buffer shift strobe
// The master side drives the inputs; the slave side is the controller itself.
interface aclk_display_ctrl_if;
    logic       one_second;
    logic [3:0] key;
    logic       alarm_button;
    logic       time_button;
    logic       show_a;
    logic       show_new_time;
    logic       load_new_a;
    logic       load_new_c;
    logic       shift;

    modport master (
        output one_second, key, alarm_button, time_button,
        input  show_a, show_new_time, load_new_a, load_new_c, shift
    );

    modport slave (
        input  one_second, key, alarm_button, time_button,
        output show_a, show_new_time, load_new_a, load_new_c, shift
    );
endinterface

// File: rtl/aclk_display_ctrl.sv
// Sequencing FSM: turns keypad and button activity into display selects and key/alarm/time load strobes.
// Latency: 1 cycle from a sampled input to the outputs (Moore; outputs decode the state register only).
// Backpressure: none; inputs are sampled every cycle and strobes are exactly one cycle wide.
//
// Ports: clock, reset (synchronous, active-high), bus (aclk_display_ctrl_if.slave).
// Parameters: NOKEY (idle keypad code), TIMEOUT_SEC (1..15 seconds of inactivity in key entry).
// Build option: define ACLK_CTRL_TIMEOUT_EN to build the inactivity timeout; without it,
// key entry is left only through key or button events and one_second is ignored.
module aclk_display_ctrl #(
    parameter logic [3:0]  NOKEY       = 4'd10,
    parameter int unsigned TIMEOUT_SEC = 10
) (
    input  logic                 clock,
    input  logic                 reset,
    aclk_display_ctrl_if.slave   bus
);

    typedef enum logic [2:0] {
        SHOW_TIME        = 3'd0,
        SHOW_ALARM       = 3'd1,
        KEY_STORED       = 3'd2,
        KEY_WAITED       = 3'd3,
        KEY_ENTRY        = 3'd4,
        SET_ALARM_TIME   = 3'd5,
        SET_CURRENT_TIME = 3'd6
    } state_t;

    state_t state;
    state_t state_nxt;
    logic   timeout;
    logic   key_vld;

    assign key_vld = (bus.key != NOKEY);

`ifdef ACLK_CTRL_TIMEOUT_EN
    localparam logic [3:0] TMO_LAST = 4'(TIMEOUT_SEC - 1);

    logic [3:0] sec_cnt;
    logic       in_entry;

    // The window runs only while waiting for key release or the next key;
    // KEY_STORED clears it so every accepted key restarts the full window.
    assign in_entry = (state == KEY_WAITED) || (state == KEY_ENTRY);
    assign timeout  = in_entry && bus.one_second && (sec_cnt == TMO_LAST);

    always_ff @(posedge clock) begin
        if (reset) begin
            sec_cnt <= 4'd0;
        end else if (!in_entry || timeout) begin
            sec_cnt <= 4'd0;
        end else if (bus.one_second) begin
            sec_cnt <= sec_cnt + 4'd1;
        end
    end
`else
    logic       unused_one_second;
    logic [3:0] unused_timeout_cfg;

    assign timeout            = 1'b0;
    assign unused_one_second  = bus.one_second;
    assign unused_timeout_cfg = 4'(TIMEOUT_SEC);
`endif

    always_ff @(posedge clock) begin
        if (reset) begin
            state <= SHOW_TIME;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt         = SHOW_TIME;
        bus.show_a        = 1'b0;
        bus.show_new_time = 1'b0;
        bus.load_new_a    = 1'b0;
        bus.load_new_c    = 1'b0;
        bus.shift         = 1'b0;

        case (state)
            SHOW_TIME: begin
                if (bus.alarm_button) begin
                    state_nxt = SHOW_ALARM;
                end else if (key_vld) begin
                    state_nxt = KEY_STORED;
                end else begin
                    state_nxt = SHOW_TIME;
                end
            end

            SHOW_ALARM: begin
                bus.show_a = 1'b1;
                state_nxt  = bus.alarm_button ? SHOW_ALARM : SHOW_TIME;
            end

            KEY_STORED: begin
                bus.shift         = 1'b1;
                bus.show_new_time = 1'b1;
                state_nxt         = KEY_WAITED;
            end

            // Holding here until release is what keeps one press to one shift;
            // buttons are deliberately ignored while a key is still down.
            KEY_WAITED: begin
                bus.show_new_time = 1'b1;
                if (!key_vld) begin
                    state_nxt = KEY_ENTRY;
                end else if (timeout) begin
                    state_nxt = SHOW_TIME;
                end else begin
                    state_nxt = KEY_WAITED;
                end
            end

            // Alarm outranks time when both buttons arrive together.
            KEY_ENTRY: begin
                bus.show_new_time = 1'b1;
                if (bus.alarm_button) begin
                    state_nxt = SET_ALARM_TIME;
                end else if (bus.time_button) begin
                    state_nxt = SET_CURRENT_TIME;
                end else if (key_vld) begin
                    state_nxt = KEY_STORED;
                end else if (timeout) begin
                    state_nxt = SHOW_TIME;
                end else begin
                    state_nxt = KEY_ENTRY;
                end
            end

            SET_ALARM_TIME: begin
                bus.load_new_a = 1'b1;
                state_nxt      = SHOW_TIME;
            end

            SET_CURRENT_TIME: begin
                bus.load_new_c = 1'b1;
                state_nxt      = SHOW_TIME;
            end

            default: begin
                state_nxt = SHOW_TIME;
            end
        endcase
    end

endmodule

// File: tb/tb_aclk_display_ctrl.sv
// Self-checking bench for aclk_display_ctrl: directed table, hand sequences and random traffic vs a reference model.
// Latency: outputs are compared 1 time unit after each rising clock edge.
// Backpressure: none; inputs are driven every cycle.
module tb_aclk_display_ctrl;

    localparam logic [3:0] NK  = 4'd10;
    localparam int         TMO = 10;
`ifdef ACLK_CTRL_TIMEOUT_EN
    localparam bit TO_EN = 1'b1;
`else
    localparam bit TO_EN = 1'b0;
`endif

    logic clock;
    logic reset;
    aclk_display_ctrl_if bus ();

    aclk_display_ctrl #(.NOKEY(NK), .TIMEOUT_SEC(TMO)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int checks = 0;
    int errors = 0;

    function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endfunction

    // Reference model: what the user sees, not how the controller encodes it.
    // view: 0 = current time, 1 = alarm time, 2 = key entry in progress.
    int m_view   = 0;
    bit m_shift  = 0;   // a key was just accepted this cycle
    bit m_held   = 0;   // accepted key not yet released
    int m_commit = 0;   // 0 none, 1 alarm, 2 current time
    int m_secs   = 0;   // idle seconds since the last accepted key

    function automatic void model_update();
        bit tmo;
        int nxt;
        bit kv;
        kv  = (bus.key != NK);
        tmo = TO_EN && bus.one_second && (m_secs == TMO - 1);
        nxt = tmo ? 0 : m_secs + int'(bus.one_second);
        if (reset) begin
            m_view = 0; m_shift = 0; m_held = 0; m_commit = 0; m_secs = 0;
        end else if (m_commit != 0) begin
            m_commit = 0; m_view = 0;
        end else if (m_shift) begin
            m_shift = 0; m_held = 1; m_secs = 0; m_view = 2;
        end else if (m_view == 1) begin
            m_view = bus.alarm_button ? 1 : 0;
        end else if (m_view == 0) begin
            if (bus.alarm_button) m_view = 1;
            else if (kv) begin m_view = 2; m_shift = 1; end
        end else if (m_held) begin
            if (!kv) begin m_held = 0; m_secs = nxt; end
            else if (tmo) begin m_view = 0; m_held = 0; m_secs = 0; end
            else m_secs = nxt;
        end else begin
            if (bus.alarm_button) begin m_commit = 1; m_view = 0; end
            else if (bus.time_button) begin m_commit = 2; m_view = 0; end
            else if (kv) m_shift = 1;
            else if (tmo) begin m_view = 0; m_secs = 0; end
            else m_secs = nxt;
        end
    endfunction

    task automatic step();
        @(posedge clock);
        model_update();
        #1;
        chk("model_show_a",        32'(bus.show_a),        32'(m_view == 1));
        chk("model_show_new_time", 32'(bus.show_new_time), 32'(m_view == 2));
        chk("model_load_new_a",    32'(bus.load_new_a),    32'(m_commit == 1));
        chk("model_load_new_c",    32'(bus.load_new_c),    32'(m_commit == 2));
        chk("model_shift",         32'(bus.shift),         32'(m_shift));
    endtask

    task automatic drive(bit r, logic [3:0] k, bit a, bit t, bit s);
        reset = r; bus.key = k; bus.alarm_button = a; bus.time_button = t; bus.one_second = s;
    endtask

    task automatic do_reset();
        drive(1, NK, 0, 0, 0);
        step();
        drive(0, NK, 0, 0, 0);
    endtask

    // Directed vectors; exp = {show_a, show_new_time, load_new_a, load_new_c, shift}
    // observed after the edge that samples the row's inputs.
    typedef struct {
        bit         rst;
        logic [3:0] key;
        bit         alm;
        bit         tim;
        logic [4:0] exp;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(bit r, logic [3:0] k, bit a, bit t, logic [4:0] e);
        vec_t v;
        v.rst = r; v.key = k; v.alm = a; v.tim = t; v.exp = e;
        return v;
    endfunction

    int shifts;
    int loads_c;
    int loads_a;
    logic [4:0] got;

    initial begin
        drive(1, 4'd5, 1, 0, 0);

        vecs.push_back(mk(1, 4'd5, 1, 0, 5'b00000)); // reset with key and alarm active
        vecs.push_back(mk(1, 4'd5, 1, 0, 5'b00000));
        vecs.push_back(mk(0, NK,   0, 0, 5'b00000)); // idle in SHOW_TIME
        vecs.push_back(mk(0, NK,   1, 0, 5'b10000)); // alarm view
        vecs.push_back(mk(0, NK,   1, 0, 5'b10000));
        vecs.push_back(mk(0, NK,   0, 0, 5'b00000)); // release -> time
        vecs.push_back(mk(0, 4'd2, 0, 0, 5'b01001)); // press -> shift
        vecs.push_back(mk(0, 4'd2, 0, 0, 5'b01000)); // held
        vecs.push_back(mk(0, 4'd2, 0, 1, 5'b01000)); // button ignored while held
        vecs.push_back(mk(0, NK,   0, 0, 5'b01000)); // release -> entry
        vecs.push_back(mk(0, NK,   1, 1, 5'b00100)); // both buttons: alarm wins
        vecs.push_back(mk(0, NK,   0, 0, 5'b00000));
        vecs.push_back(mk(0, 4'd4, 0, 0, 5'b01001));
        vecs.push_back(mk(0, NK,   0, 0, 5'b01000));
        vecs.push_back(mk(0, NK,   0, 0, 5'b01000));
        vecs.push_back(mk(0, NK,   0, 1, 5'b00010)); // time commit
        vecs.push_back(mk(0, 4'd6, 0, 0, 5'b00000)); // strobe state leaves unconditionally
        vecs.push_back(mk(0, 4'd6, 0, 0, 5'b01001));
        vecs.push_back(mk(0, NK,   1, 0, 5'b01000)); // alarm during KEY_STORED ignored
        vecs.push_back(mk(0, NK,   0, 0, 5'b01000));
        vecs.push_back(mk(0, NK,   0, 1, 5'b00010));
        vecs.push_back(mk(1, NK,   0, 0, 5'b00000)); // reset on the strobe state drops it
        vecs.push_back(mk(0, 4'd1, 0, 0, 5'b01001));
        vecs.push_back(mk(1, 4'd1, 0, 0, 5'b00000)); // reset mid-entry
        vecs.push_back(mk(0, NK,   0, 0, 5'b00000));
        vecs.push_back(mk(0, 4'd3, 1, 0, 5'b10000)); // alarm beats key in SHOW_TIME
        vecs.push_back(mk(0, 4'd3, 0, 0, 5'b00000));
        vecs.push_back(mk(0, 4'd3, 0, 0, 5'b01001));
        vecs.push_back(mk(0, 4'd15,0, 0, 5'b01000)); // non-NOKEY code keeps it held
        vecs.push_back(mk(0, NK,   0, 0, 5'b01000));
        vecs.push_back(mk(0, 4'd0, 0, 0, 5'b01001)); // key 0 is a real digit
        vecs.push_back(mk(1, NK,   0, 0, 5'b00000));

        foreach (vecs[i]) begin
            drive(vecs[i].rst, vecs[i].key, vecs[i].alm, vecs[i].tim, 0);
            step();
            got = {bus.show_a, bus.show_new_time, bus.load_new_a, bus.load_new_c, bus.shift};
            chk($sformatf("vec%0d", i), 32'(got), 32'(vecs[i].exp));
        end

        // Four keys, each held 3 cycles, then a time commit.
        do_reset();
        shifts = 0;
        loads_c = 0;
        for (int k = 1; k <= 4; k++) begin
            bus.key = 4'(k);
            for (int c = 0; c < 3; c++) begin
                step();
                chk("entry_shift_timing", 32'(bus.shift), 32'(c == 0));
                chk("entry_show_new_time", 32'(bus.show_new_time), 32'd1);
                shifts += int'(bus.shift);
            end
            bus.key = NK;
            for (int c = 0; c < 2; c++) begin
                step();
                chk("entry_gap_show_new_time", 32'(bus.show_new_time), 32'd1);
                shifts += int'(bus.shift);
                loads_c += int'(bus.load_new_c);
            end
        end
        chk("entry_shift_count", 32'(shifts), 32'd4);
        bus.time_button = 1'b1;
        step();
        loads_c += int'(bus.load_new_c);
        bus.time_button = 1'b0;
        step();
        chk("entry_load_c_count", 32'(loads_c), 32'd1);
        chk("entry_back_to_time", 32'({bus.show_a, bus.show_new_time, bus.load_new_c}), 32'd0);

        // Alarm view for 5 cycles.
        bus.alarm_button = 1'b1;
        for (int c = 0; c < 5; c++) begin
            step();
            chk("alarm_view_held", 32'(bus.show_a), 32'd1);
        end
        bus.alarm_button = 1'b0;
        step();
        chk("alarm_view_release", 32'(bus.show_a), 32'd0);

        // A key held 20 cycles gives one shift.
        do_reset();
        shifts = 0;
        bus.key = 4'd3;
        for (int c = 0; c < 20; c++) begin
            step();
            shifts += int'(bus.shift);
        end
        chk("held_key_shift_count", 32'(shifts), 32'd1);
        chk("held_key_show_new_time", 32'(bus.show_new_time), 32'd1);
        bus.key = NK;
        step();
        chk("held_key_release_entry", 32'(bus.show_new_time), 32'd1);

        // Inactivity timeout (or its absence).
        do_reset();
        bus.key = 4'd7;
        step();
        bus.key = NK;
        step();
        step();
        loads_a = 0;
        loads_c = 0;
        for (int p = 1; p <= 30; p++) begin
            bus.one_second = 1'b1;
            step();
            loads_a += int'(bus.load_new_a);
            loads_c += int'(bus.load_new_c);
            if (TO_EN && p == TMO - 1) chk("timeout_before_last", 32'(bus.show_new_time), 32'd1);
            if (TO_EN && p == TMO)     chk("timeout_at_last", 32'(bus.show_new_time), 32'd0);
            bus.one_second = 1'b0;
            step();
        end
        chk("timeout_no_load", 32'(loads_a + loads_c), 32'd0);
        chk("timeout_final_view", 32'(bus.show_new_time), 32'(!TO_EN));

        // A new key restarts the window.
        do_reset();
        bus.key = 4'd7;
        step();
        bus.key = NK;
        step();
        step();
        for (int p = 1; p < TMO; p++) begin
            bus.one_second = 1'b1;
            step();
            bus.one_second = 1'b0;
            step();
        end
        bus.key = 4'd8;
        step();
        chk("restart_shift", 32'(bus.shift), 32'd1);
        bus.key = NK;
        step();
        step();
        for (int p = 1; p <= TMO; p++) begin
            bus.one_second = 1'b1;
            step();
            if (p == TMO - 1) chk("restart_before_last", 32'(bus.show_new_time), 32'd1);
            if (p == TMO)     chk("restart_at_last", 32'(bus.show_new_time), 32'(!TO_EN));
            bus.one_second = 1'b0;
            step();
        end

        // Random traffic against the model.
        do_reset();
        for (int c = 0; c < 3000; c++) begin
            logic [3:0] k;
            int r;
            r = int'($urandom_range(0, 99));
            if (r < 55)      k = NK;
            else if (r < 95) k = 4'($urandom_range(0, 9));
            else             k = 4'($urandom_range(11, 15));
            drive(($urandom_range(0, 199) == 0),
                  k,
                  ($urandom_range(0, 9) == 0),
                  ($urandom_range(0, 9) == 0),
                  ($urandom_range(0, 3) == 0));
            step();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/aclk_display_ctrl.md
# aclk_display_ctrl

Main sequencing FSM for the alarm clock display path. It decodes keypad and button activity into the display-select and load strobes for the four-digit LCD display block and its key/alarm/time registers. It decides whether the display shows current time, alarm time or the key-entry buffer, and when a keyed value is committed. It sits between the keypad decoder and the LCD display block and runs on the system clock with a 1 Hz enable pulse.

## Interface
- `NOKEY`, default 4'd10: keypad code meaning "no key pressed".
- `TIMEOUT_SEC`, default 10, legal range 1..15: number of `one_second` pulses of inactivity before key entry is abandoned.
- `clock` input 1: system clock; all state changes on its rising edge.
- `reset` input 1: synchronous, active-high; forces SHOW_TIME and clears the timeout counter.
- `one_second` input 1: single-cycle 1 Hz enable pulse.
- `key` input 4: current keypad code; `NOKEY` when idle; 0..9 are digits.
- `alarm_button` input 1: level, high while the alarm button is held.
- `time_button` input 1: level, high while the time button is held.
- `show_a` output 1: display selects alarm time.
- `show_new_time` output 1: display selects the key-entry buffer.
- `load_new_a` output 1: one-cycle strobe; commit key buffer to alarm register.
- `load_new_c` output 1: one-cycle strobe; commit key buffer to current time.
- `shift` output 1: one-cycle strobe; shift `key` into the key buffer.

## Operation
- Moore FSM; all outputs are decoded from the registered state only. Outputs not listed for a state are 0.
- SHOW_TIME (reset state, all outputs 0):
  - `alarm_button` -> SHOW_ALARM;
  - else `key != NOKEY` -> KEY_STORED.
- SHOW_ALARM (`show_a=1`):
  - `alarm_button==0` -> SHOW_TIME;
  - else stay. Keys are ignored.
- KEY_STORED (`shift=1`, `show_new_time=1`): unconditional -> KEY_WAITED. Exactly one shift per key press.
- KEY_WAITED (`show_new_time=1`):
  - `key==NOKEY` -> KEY_ENTRY;
  - else timeout -> SHOW_TIME;
  - else stay, which rejects a held key.
- KEY_ENTRY (`show_new_time=1`), priority order:
  - `alarm_button` -> SET_ALARM_TIME;
  - else `time_button` -> SET_CURRENT_TIME;
  - else `key != NOKEY` -> KEY_STORED;
  - else timeout -> SHOW_TIME.
- SET_ALARM_TIME (`load_new_a=1`): unconditional -> SHOW_TIME.
- SET_CURRENT_TIME (`load_new_c=1`): unconditional -> SHOW_TIME.
- Unused state encodings -> SHOW_TIME on the next edge.
- Timeout counter:
  - Width 4 bits, unsigned.
  - Counts `one_second` pulses only while in KEY_WAITED or KEY_ENTRY.
  - Cleared to 0 in every other state, including KEY_STORED, so each new key restarts the window.
  - Timeout is true when `one_second==1` and count `== TIMEOUT_SEC-1`.
  - On timeout the counter clears and does not wrap.
- Simultaneous `alarm_button` and `time_button` in KEY_ENTRY: the alarm wins.
- A button press during KEY_WAITED is ignored.

## Timing
- Reset: state becomes SHOW_TIME and the counter 0 on the first edge with `reset=1`. All outputs are 0 from that edge onward.
- Reset mid-operation, in any state including a strobe state: the strobe is dropped and no load occurs after the reset edge.
- Input-to-output latency is 1 cycle: an input sampled on edge N changes the outputs after edge N.
- `shift`, `load_new_a` and `load_new_c` are each exactly 1 cycle wide.
- Key press to `shift` high: 1 cycle.
- Timeout: state returns to SHOW_TIME on the same edge that samples the `TIMEOUT_SEC`-th `one_second` pulse.

## Configuration
- `ACLK_CTRL_TIMEOUT_EN`:
  - Defined: timeout counter and timeout transitions exist as specified.
  - Undefined: no counter is built and timeout is constant 0. KEY_WAITED and KEY_ENTRY are left only via key or button events; `one_second` is unused.

## Test plan
- Reset: hold `reset` 2 cycles while `key=5` and `alarm_button=1` -> all outputs 0; state SHOW_TIME after release when inputs are idle.
- Key entry and time set:
  - Stimulus: keys 1, 2, 3, 4, each held 3 cycles and separated by `NOKEY`; then `time_button` for 1 cycle.
  - Required: exactly 4 `shift` pulses, each 1 cycle after its press edge; `show_new_time=1` throughout; one `load_new_c` pulse; then SHOW_TIME.
- Alarm view and priority:
  - `alarm_button` held 5 cycles from SHOW_TIME -> `show_a=1` for 5 cycles, back to 0 one cycle after release.
  - From KEY_ENTRY, both buttons in the same cycle -> `load_new_a` only.
- Timeout (macro defined, `TIMEOUT_SEC=10`):
  - Key 7, then 10 `one_second` pulses -> SHOW_TIME on the 10th pulse edge, no load strobe.
  - 9 pulses, then key 8 -> counter restarts and timeout needs 10 further pulses.
- Held key: key 3 held 20 cycles -> a single `shift` pulse; state stays KEY_WAITED until `NOKEY`.
- Macro undefined: key 7 then 30 `one_second` pulses -> stays KEY_ENTRY with `show_new_time=1`.
